ro_monitor_ctrl: RTL

Sequencer for the on-die ring-oscillator process monitor built from mcu7t5v0 inverter stages (inv_2 chains).
- Enables one of NUM_RO oscillators, waits for it to settle, then counts its divided output over a programmable window of CLK cycles.
- Returns the count over a valid/ready handshake.
- Sits between the characterization register bank and the oscillator array.

---
 rtl/ro_monitor_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ro_monitor_ctrl.sv
// rtl/ro_monitor_ctrl.sv - ring-oscillator process monitor sequencer
// Enables one oscillator, settles, counts synchronized RO_OUT rising edges over a window.
module ro_monitor_ctrl #(
  parameter int NUM_RO        = 4,
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [3:0]        SEL,
  input  logic [WIN_W-1:0]  WINDOW,
  input  logic              RO_OUT,
  output logic [NUM_RO-1:0] RO_EN,
  output logic              BUSY,
  output logic              VALID,
  input  logic              READY,
  output logic [CNT_W-1:0]  RESULT,
  output logic              OVF,
  output logic              ERR
);

  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [NUM_RO-1:0]  ro_en_q, ro_en_d;

  logic               edge_det;
  logic               sel_ok;
  logic               win_last;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_inc;

  // sync_q[1] is the metastability-safe sample; sync_q[2] is its one-cycle history.
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign sel_ok   = ({1'b0, SEL} < 5'(NUM_RO));
  assign win_last = (tmr_q == (TMR_W'(win_q) - TMR_W'(1)));

  // Saturating increment: an edge arriving at full scale is dropped and flagged.
  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (edge_det) begin
      if (cnt_q == CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        cnt_inc = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[1:0], RO_OUT};
    win_d    = win_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    ro_en_d  = ro_en_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          win_d = WINDOW;
          tmr_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (sel_ok) begin
            state_d = S_SETTLE;
            err_d   = 1'b0;
            ro_en_d = NUM_RO'(1) << SEL;
          end else begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            result_d = '0;
            ro_en_d  = '0;
          end
        end
      end

      S_SETTLE: begin
        if (ABORT) begin
          state_d = S_IDLE;
          ro_en_d = '0;
        end else if (tmr_q == SETTLE_LAST) begin
          tmr_d = '0;
          if (win_q == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            ro_en_d  = '0;
          end else begin
            state_d = S_MEASURE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_MEASURE: begin
        if (ABORT) begin
          state_d = S_IDLE;
          ro_en_d = '0;
        end else begin
          cnt_d = cnt_inc;
          ovf_d = ovf_inc;
          tmr_d = tmr_q + TMR_W'(1);
          if (win_last) begin
            state_d  = S_DONE;
            result_d = cnt_inc;
            ro_en_d  = '0;
          end
        end
      end

      S_DONE: begin
        if (READY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ro_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      win_q    <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      ro_en_q  <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      win_q    <= win_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      ro_en_q  <= ro_en_d;
    end
  end

  assign RO_EN  = ro_en_q;
  assign BUSY   = (state_q != S_IDLE);
  assign VALID  = (state_q == S_DONE);
  assign RESULT = result_q;
  assign OVF    = ovf_q;
  assign ERR    = err_q;

endmodule
